// File: rtl/rb_sched_pkg.sv
// Shared state encoding and register-bank address map for the rb_sched scheduler.
package rb_sched_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, MWAIT, RESP} state_t;

  typedef enum logic [1:0] {CLS_FAST, CLS_M, CLS_UNMAP} addr_cls_t;

  localparam logic [6:0] ADDR_M_LO     = 7'h50;
  localparam logic [6:0] ADDR_FAST2_LO = 7'h60;
  localparam logic [6:0] ADDR_UNMAP_LO = 7'h70;
  localparam logic [6:0] ADDR_PC       = 7'h69;
  localparam logic [6:0] ADDR_EP       = 7'h6F;

  function automatic addr_cls_t addrClass(input logic [6:0] addr);
    addr_cls_t cls;
    if (addr >= ADDR_UNMAP_LO) cls = CLS_UNMAP;
    else if (addr >= ADDR_M_LO && addr < ADDR_FAST2_LO) cls = CLS_M;
    else cls = CLS_FAST;
    return cls;
  endfunction

  // pc and ep may only be written by the debug requester
  function automatic logic isReadOnly(input logic [6:0] addr);
    return (addr == ADDR_PC) || (addr == ADDR_EP);
  endfunction

endpackage

// File: rtl/rb_rr_pick.sv
// Round-robin picker: returns the one-hot winner, searching upward from the pointer.
module rb_rr_pick #(
  parameter int N_REQ = 3,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_winner
);

  always_comb begin : pick
    int   idx;
    logic found;
    o_winner = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(i_ptr) + k) % N_REQ;
      if (!found && i_req[idx]) begin
        o_winner[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rb_sched.sv
// Arbitrates N_REQ requesters onto one register bank, with a slow handshake window
// for m-space and access checks on the debug-only registers.
module rb_sched
  import rb_sched_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           req_we,
  input  logic [N_REQ-1:0][6:0]      req_addr,
  input  logic [N_REQ-1:0][DW-1:0]   req_wdata,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic                       rsp_err,
  output logic [DW-1:0]              rsp_rdata,
  output logic                       rb_en,
  output logic                       rb_we,
  output logic [6:0]                 rb_addr,
  output logic [DW-1:0]              rb_wdata,
  input  logic [DW-1:0]              rb_rdata,
  output logic                       m_req,
  input  logic                       m_ack
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t          r_state, w_next;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_idx;
  logic            r_we;
  logic [6:0]      r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_mdata;
  logic            r_err;
  logic            r_fromM;

  logic [N_REQ-1:0] w_win;
  logic [PW-1:0]    w_winIdx;
  logic             w_selWe;
  logic [6:0]       w_selAddr;
  logic [DW-1:0]    w_selWdata;
  addr_cls_t        w_cls;
  logic             w_illegal;
  logic             w_accept;

  rb_rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_winner (w_win)
  );

  always_comb begin
    w_winIdx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win[i]) w_winIdx = PW'(i);
    end
  end

  assign w_selWe    = req_we[w_winIdx];
  assign w_selAddr  = req_addr[w_winIdx];
  assign w_selWdata = req_wdata[w_winIdx];
  assign w_cls      = addrClass(w_selAddr);
  assign w_illegal  = w_selWe && isReadOnly(w_selAddr) && (w_winIdx != PW'(N_REQ - 1));
  assign w_accept   = (r_state == IDLE) && (|req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // gnt is combinational so the winner is acknowledged in the same IDLE cycle;
  // it is masked by rst so every output is quiet while reset is held.
  always_comb begin
    w_next = r_state;
    gnt    = '0;
    case (r_state)
      IDLE: begin
        if (|req) begin
          if (!rst) gnt = w_win;
          if (w_cls == CLS_UNMAP || w_illegal) w_next = RESP;
          else if (w_cls == CLS_M)             w_next = MWAIT;
          else                                 w_next = ISSUE;
        end
      end
      ISSUE:   w_next = RESP;
      MWAIT:   if (m_ack) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mdata <= '0;
      r_err   <= 1'b0;
      r_fromM <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ptr   <= (w_winIdx == PW'(N_REQ - 1)) ? '0 : w_winIdx + 1'b1;
        r_idx   <= w_winIdx;
        r_we    <= w_selWe;
        r_addr  <= w_selAddr;
        r_wdata <= w_selWdata;
        r_err   <= (w_cls == CLS_UNMAP) || w_illegal;
        r_fromM <= (w_cls == CLS_M);
      end
      // m-space read data is only on the bus during the ack cycle
      if (r_state == MWAIT && m_ack) r_mdata <= rb_rdata;
    end
  end

  assign rb_en    = (r_state == ISSUE);
  assign m_req    = (r_state == MWAIT);
  assign rb_we    = (rb_en || m_req) && r_we;
  assign rb_addr  = r_addr;
  assign rb_wdata = r_wdata;

  always_comb begin
    rsp_valid = '0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    if (r_state == RESP) begin
      rsp_valid[r_idx] = 1'b1;
      rsp_err          = r_err;
      if (!r_err && !r_we) rsp_rdata = r_fromM ? r_mdata : rb_rdata;
    end
  end

endmodule

// File: tb/tb_rb_sched.sv
// Randomised scoreboard bench for rb_sched: requester agents, a bank/m-space responder
// and an abstract reference model predicting grants and responses.
module tb_rb_sched;

  localparam int N  = 3;
  localparam int DW = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           req;
  logic [N-1:0]           req_we;
  logic [N-1:0][6:0]      req_addr;
  logic [N-1:0][DW-1:0]   req_wdata;
  logic [N-1:0]           gnt;
  logic [N-1:0]           rsp_valid;
  logic                   rsp_err;
  logic [DW-1:0]          rsp_rdata;
  logic                   rb_en;
  logic                   rb_we;
  logic [6:0]             rb_addr;
  logic [DW-1:0]          rb_wdata;
  logic [DW-1:0]          rb_rdata;
  logic                   m_req;
  logic                   m_ack;

  rb_sched #(.N_REQ(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .rb_en(rb_en), .rb_we(rb_we), .rb_addr(rb_addr),
    .rb_wdata(rb_wdata), .rb_rdata(rb_rdata), .m_req(m_req), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              idx;
    bit              isErr;
    bit              isM;
    bit              we;
    logic [6:0]      addr;
    logic [DW-1:0]   wdata;
    logic [DW-1:0]   rdata;
    int              gntCycle;
  } exp_t;

  typedef struct {
    int idx;
    int cyc;
  } grant_t;

  exp_t            expQ[$];
  grant_t          grantLog[$];
  logic [DW-1:0]   refMem[128];
  logic [DW-1:0]   bankMem[128];
  logic [DW-1:0]   bankQ = '0;
  logic [DW-1:0]   mData = '0;
  int              refPtr = 0;
  bit              refBusy = 0;
  int              busyCnt = 0;
  logic [N-1:0]    gntSeen = '0;
  int              cycle = 0;
  int              ackCycle = 0;
  int              mForceDelay = -1;
  int              mReqCycles = 0;
  int              testsRun = 0;
  int              testsFailed = 0;

  assign rb_rdata = m_ack ? mData : bankQ;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic int rrWinner(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [6:0] randAddr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return 7'($urandom_range(0, 'h4F));
      4, 5:       return 7'($urandom_range('h50, 'h5F));
      6:          return ($urandom_range(0, 1) != 0) ? 7'h69 : 7'h6F;
      7:          return 7'($urandom_range('h60, 'h6F));
      default:    return 7'($urandom_range('h70, 'h7F));
    endcase
  endfunction

  task automatic raiseReq(input int i, input bit we, input logic [6:0] addr, input logic [DW-1:0] wd);
    req_we[i]    = we;
    req_addr[i]  = addr;
    req_wdata[i] = wd;
    req[i]       = 1'b1;
  endtask

  // One cycle of requester behaviour: drop after grant, optional re-raise or random traffic
  task automatic applyStimulus(input bit randomMode, input bit holdMode);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (gntSeen[i]) begin
        gntSeen[i] = 1'b0;
        req[i]     = 1'b0;
        if (holdMode) raiseReq(i, 1'b0, 7'($urandom_range(0, 'h4F)), '0);
      end else if (randomMode) begin
        if (req[i] && $urandom_range(0, 19) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0)
          raiseReq(i, 1'($urandom_range(0, 1)), randAddr(), $urandom);
      end
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((refBusy || expQ.size() != 0 || req != '0) && n < 200) begin
      applyStimulus(1'b0, 1'b0);
      n++;
    end
    checkOutput("drain", 64'(n < 200), 64'(1));
  endtask

  // Reference model: predicts each grant and pushes the expected response
  initial begin : grantSide
    exp_t         e;
    logic [N-1:0] expGnt;
    int           w;
    forever begin
      @(negedge clk);
      if (rst) begin
        refBusy = 0;
        refPtr  = 0;
        busyCnt = 0;
        gntSeen = '0;
        expQ.delete();
      end else begin
        expGnt = '0;
        w      = -1;
        if (!refBusy && req != '0) begin
          w         = rrWinner(req, refPtr);
          expGnt[w] = 1'b1;
        end
        if (gnt != '0 || expGnt != '0) checkOutput("gnt", 64'(gnt), 64'(expGnt));
        for (int i = 0; i < N; i++) begin
          if (gnt[i]) grantLog.push_back('{idx: i, cyc: cycle});
        end
        gntSeen |= gnt;
        if (w >= 0) begin
          e.idx      = w;
          e.we       = req_we[w];
          e.addr     = req_addr[w];
          e.wdata    = req_wdata[w];
          e.isErr    = (e.addr >= 7'h70) ||
                       (e.we && (e.addr == 7'h69 || e.addr == 7'h6F) && w != N - 1);
          e.isM      = !e.isErr && e.addr >= 7'h50 && e.addr <= 7'h5F;
          e.rdata    = '0;
          e.gntCycle = cycle;
          if (!e.isErr) begin
            if (e.we) refMem[e.addr] = e.wdata;
            else      e.rdata = refMem[e.addr];
          end
          expQ.push_back(e);
          refBusy = 1;
          busyCnt = 0;
          refPtr  = (w + 1) % N;
        end else if (refBusy && rsp_valid != '0) begin
          refBusy = 0;
        end else if (refBusy) begin
          busyCnt++;
          if (busyCnt > 50) begin
            checkOutput("rsp_timeout", 64'(busyCnt), 64'(0));
            refBusy = 0;
            expQ.delete();
          end
        end
      end
    end
  end

  // Monitor: compares bus activity and responses against the scoreboard head
  initial begin : monitor
    exp_t e;
    int   expCyc;
    bit   mPrev = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mPrev = 0;
      end else begin
        if (m_req) mReqCycles++;
        if (rb_en) begin
          checkOutput("rb_en_pending", 64'(expQ.size() > 0), 64'(1));
          if (expQ.size() > 0) begin
            e = expQ[0];
            checkOutput("rb_en_kind", 64'({e.isM, e.isErr}), 64'(0));
            checkOutput("rb_en_cycle", 64'(cycle), 64'(e.gntCycle + 1));
            checkOutput("rb_addr", 64'(rb_addr), 64'(e.addr));
            checkOutput("rb_we", 64'(rb_we), 64'(e.we));
            if (e.we) checkOutput("rb_wdata", 64'(rb_wdata), 64'(e.wdata));
          end
        end
        if (m_req && !mPrev) begin
          checkOutput("m_req_pending", 64'(expQ.size() > 0), 64'(1));
          if (expQ.size() > 0) begin
            e = expQ[0];
            checkOutput("m_req_kind", 64'({e.isM, e.isErr}), 64'(2));
            checkOutput("m_addr", 64'(rb_addr), 64'(e.addr));
            checkOutput("m_we", 64'(rb_we), 64'(e.we));
            if (e.we) checkOutput("m_wdata", 64'(rb_wdata), 64'(e.wdata));
          end
        end
        mPrev = m_req;
        if (rsp_valid != '0) begin
          checkOutput("rsp_pending", 64'(expQ.size() > 0), 64'(1));
          if (expQ.size() > 0) begin
            e      = expQ.pop_front();
            expCyc = e.isErr ? e.gntCycle + 1 : (e.isM ? ackCycle + 1 : e.gntCycle + 2);
            checkOutput("rsp_valid", 64'(rsp_valid), 64'(1) << e.idx);
            checkOutput("rsp_err", 64'(rsp_err), 64'(e.isErr));
            checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            checkOutput("rsp_latency", 64'(cycle), 64'(expCyc));
          end
        end
      end
    end
  end

  // Fast bank: one-cycle registered read
  initial begin : bankModel
    bit            pEn, pWe;
    logic [6:0]    pAddr;
    logic [DW-1:0] pWd;
    forever begin
      @(negedge clk);
      pEn = rb_en; pWe = rb_we; pAddr = rb_addr; pWd = rb_wdata;
      @(posedge clk);
      #1;
      if (pEn) begin
        if (pWe) bankMem[pAddr] = pWd;
        else     bankQ = bankMem[pAddr];
      end
    end
  end

  // Slow m-space responder with a random or forced ack delay
  initial begin : mResponder
    int mCnt = -1;
    m_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || m_ack) begin
        m_ack = 1'b0;
        mCnt  = -1;
      end else if (m_req) begin
        if (mCnt < 0) mCnt = (mForceDelay >= 0) ? mForceDelay : int'($urandom_range(0, 5));
        if (mCnt == 0) begin
          m_ack    = 1'b1;
          ackCycle = cycle;
          if (rb_we) bankMem[rb_addr] = rb_wdata;
          else       mData = bankMem[rb_addr];
        end else begin
          mCnt--;
        end
      end
    end
  end

  initial begin : mainSeq
    int n;
    rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    for (int a = 0; a < 128; a++) begin
      refMem[a]  = $urandom;
      bankMem[a] = refMem[a];
    end
    refMem[7'h12]  = 32'hDEADBEEF;
    bankMem[7'h12] = 32'hDEADBEEF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_gnt", 64'(gnt), 64'(0));
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    checkOutput("reset_rb_en", 64'(rb_en), 64'(0));
    checkOutput("reset_m_req", 64'(m_req), 64'(0));

    // All requesters hold req from the first cycle out of reset
    @(posedge clk);
    #1;
    rst = 1'b0;
    grantLog.delete();
    for (int i = 0; i < N; i++) raiseReq(i, 1'b0, 7'($urandom_range(0, 'h4F)), '0);
    repeat (12) applyStimulus(1'b0, 1'b1);
    req = '0;
    waitIdle();
    checkOutput("rr_count", 64'(grantLog.size() >= 4), 64'(1));
    if (grantLog.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        checkOutput($sformatf("rr_order%0d", k), 64'(grantLog[k].idx), 64'(k % 3));
        if (k > 0) checkOutput($sformatf("rr_spacing%0d", k),
                               64'(grantLog[k].cyc - grantLog[k-1].cyc), 64'(3));
      end
    end

    raiseReq(1, 1'b0, 7'h12, '0);
    waitIdle();

    mForceDelay = 4;
    mReqCycles  = 0;
    raiseReq(0, 1'b1, 7'h55, 32'h1234);
    waitIdle();
    checkOutput("m_req_held", 64'(mReqCycles), 64'(5));
    mForceDelay = -1;
    raiseReq(2, 1'b0, 7'h55, '0);
    waitIdle();

    raiseReq(0, 1'b1, 7'h69, 32'hAAAA);
    waitIdle();
    raiseReq(2, 1'b1, 7'h69, 32'h5555);
    waitIdle();
    raiseReq(1, 1'b0, 7'h69, '0);
    waitIdle();

    raiseReq(1, 1'b0, 7'h75, '0);
    waitIdle();

    // Reset in the middle of a slow access
    mForceDelay = 20;
    raiseReq(2, 1'b0, 7'h5A, '0);
    n = 0;
    while (!m_req && n < 20) begin
      applyStimulus(1'b0, 1'b0);
      n++;
    end
    checkOutput("mwait_reached", 64'(m_req), 64'(1));
    applyStimulus(1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_m_req", 64'(m_req), 64'(0));
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = '0;
    mForceDelay = -1;
    raiseReq(1, 1'b0, 7'h21, '0);
    raiseReq(2, 1'b0, 7'h22, '0);
    waitIdle();

    repeat (3000) applyStimulus(1'b1, 1'b0);
    waitIdle();
    checkOutput("scoreboard_empty", 64'(expQ.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/rb_sched.md
RB_SCHED -- requirements
Module: rb_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 3: number of requesters; requester N_REQ-1 is debug.
REQ-002 SHALL have parameter DW, default 32: register data width.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port req, input, N_REQ: per-requester access request, held until gnt.
REQ-006 SHALL have port req_we, input, N_REQ: per-requester write enable, 1 = write.
REQ-007 SHALL have port req_addr, input, N_REQ x 7: per-requester register address.
REQ-008 SHALL have port req_wdata, input, N_REQ x DW: per-requester write data.
REQ-009 SHALL have port gnt, output, N_REQ: one-hot, one-cycle acceptance pulse.
REQ-010 SHALL have port rsp_valid, output, N_REQ: one-hot, one-cycle completion pulse.
REQ-011 SHALL have port rsp_err, output, 1: error flag, qualified by rsp_valid.
REQ-012 SHALL have port rsp_rdata, output, DW: read data, qualified by rsp_valid with read access.
REQ-013 SHALL have port rb_en, output, 1: register-bank access strobe.
REQ-014 SHALL have port rb_we, output, 1: register-bank write.
REQ-015 SHALL have port rb_addr, output, 7: register-bank address.
REQ-016 SHALL have port rb_wdata, output, DW: register-bank write data.
REQ-017 SHALL have port rb_rdata, input, DW: bank read data, valid the cycle after rb_en.
REQ-018 SHALL have port m_req, output, 1: slow m-space (0x50-0x5F) access request, held until m_ack.
REQ-019 SHALL have port m_ack, input, 1: m-space completion; read data on rb_rdata in the same cycle.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, MWAIT, RESP.
REQ-021 In IDLE with any req, SHALL pick a winner round-robin, pulse its gnt that cycle and latch we/addr/wdata/index.
REQ-022 Round-robin rule: the pointer resets to 0; after a grant to i, priority starts at (i+1) mod N_REQ.
REQ-023 Address classes: 0x00-0x4F and 0x60-0x6F are fast; 0x50-0x5F is slow (m); 0x70-0x7F is unmapped.
REQ-024 Address 0x69 (pc) and 0x6F (ep) are read-only to every requester except debug.
REQ-025 IDLE->ISSUE for a legal fast access; ISSUE drives rb_en=1 plus we/addr/wdata for exactly one cycle, then goes to RESP.
REQ-026 IDLE->MWAIT for a legal m access; m_req and rb_addr/rb_we/rb_wdata stay stable until m_ack, then RESP; no timeout.
REQ-027 IDLE->RESP directly for an unmapped address or an illegal write; in this case there is no rb_en and no m_req.
REQ-028 RESP SHALL pulse rsp_valid for the latched requester for one cycle, with rsp_err=1 for the IDLE->RESP path.
REQ-029 RESP SHALL present rsp_rdata as the registered rb_rdata for reads; it is 0 for writes and errors.
REQ-030 RESP always returns to IDLE, so a new grant is possible the cycle after RESP.
REQ-031 Latency: fast access takes gnt at t and rsp_valid at t+2; m access takes rsp_valid 1 cycle after m_ack.
REQ-032 A req deasserted before gnt SHALL be ignored without side effects; a new req from the requester currently in service waits for IDLE.
REQ-033 gnt SHALL never be asserted outside IDLE; at most one gnt and at most one rsp_valid bit are set per cycle.

Reset
REQ-034 rst SHALL asynchronously force IDLE, pointer=0 and all outputs to 0, including an in-flight m_req, whose response is discarded.
REQ-035 First grant after rst release SHALL be possible on the first clock edge with rst low.

Structure
REQ-036 State enum, address class bounds (0x50, 0x60, 0x70), 0x69 and 0x6F SHALL live in the shared commons package.
REQ-037 Round-robin selection SHALL be sub-module rb_rr_pick (req vector + pointer -> one-hot winner).

Verification
REQ-038 Only requester 1 reads 0x12, with rb_rdata=0xDEADBEEF -> gnt[1] at t, rb_en at t+1, rsp_valid[1] at t+2 with rdata 0xDEADBEEF.
REQ-039 All 3 requesters hold req continuously -> grants in order 0,1,2,0, one grant every 3 cycles.
REQ-040 Requester 0 writes 0x55 with data 0x1234 and m_ack arrives 5 cycles later -> m_req held 5 cycles, rsp_valid[0] the cycle after m_ack, rsp_err=0.
REQ-041 Requester 0 writes 0x69 -> rsp_err=1, no rb_en; then debug writes 0x69 -> rb_we=1, rb_addr=0x69.
REQ-042 Read of 0x75 -> rsp_valid with rsp_err=1 at gnt+1, with no bank or m access.
REQ-043 rst asserted during MWAIT -> m_req=0 immediately, no rsp_valid, and the next request is granted normally.
